// File: rtl/directory_controller.sv
`default_nettype none
// ============================================================================
// directory_controller : home-node coherence directory (state + sharer vector)
// Optional DIR_STATS_EN adds saturating invalidate/fetch pulse counters.
// Revision: 1.0
// ============================================================================
module directory_controller #(
  parameter  int NUM_NODES = 4,
  parameter  int NUM_LINES = 16,
  localparam int NODE_W    = $clog2(NUM_NODES),
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [1:0]           i_req_type,
  input  logic [NODE_W-1:0]    i_req_node,
  input  logic [IDX_W-1:0]     i_req_index,
  output logic                 o_inv_valid,
  output logic [NUM_NODES-1:0] o_inv_mask,
  output logic                 o_fetch_valid,
  output logic [NODE_W-1:0]    o_fetch_node,
  output logic                 o_fetch_inval,
  input  logic                 i_ack_valid,
  input  logic [NODE_W-1:0]    i_ack_node,
  output logic                 o_reply_valid,
  output logic [NODE_W-1:0]    o_reply_node,
  output logic [1:0]           o_reply_state,
  output logic                 o_busy
`ifdef DIR_STATS_EN
  ,
  output logic [15:0]          o_stat_inval,
  output logic [15:0]          o_stat_fetch
`endif
);

  localparam logic [1:0] c_UNCACHED = 2'b01;
  localparam logic [1:0] c_SHARED   = 2'b10;
  localparam logic [1:0] c_MODIFIED = 2'b11;
  localparam logic [1:0] c_REQ_RD   = 2'b00;
  localparam logic [1:0] c_REQ_WB   = 2'b11;
  localparam logic [NUM_NODES-1:0] c_ONE = NUM_NODES'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOOKUP     = 3'd1,
    S_INVAL_WAIT = 3'd2,
    S_FETCH_WAIT = 3'd3,
    S_REPLY      = 3'd4
  } fsm_t;

  fsm_t                 r_fsm, w_fsm_nxt;
  logic [1:0]           r_state_tbl  [NUM_LINES];
  logic [NUM_NODES-1:0] r_sharer_tbl [NUM_LINES];
  logic [1:0]           r_type;
  logic [NODE_W-1:0]    r_node;
  logic [IDX_W-1:0]     r_index;
  logic [NUM_NODES-1:0] r_pending, w_pending_nxt;
  logic [1:0]           r_new_state, w_new_state;
  logic [NUM_NODES-1:0] r_new_sharers, w_new_sharers;
  logic [1:0]           r_reply_state, w_reply_state;
  logic                 w_inv_valid, w_fetch_valid, w_fetch_inval;
  logic [NUM_NODES-1:0] w_inv_mask;
  logic [NODE_W-1:0]    w_fetch_node;
  logic [1:0]           w_cur_state;
  logic [NUM_NODES-1:0] w_cur_sharers, w_req_oh, w_others;
  logic [NODE_W-1:0]    w_owner;
  logic                 w_node_ok, w_accept;

  function automatic logic [NODE_W-1:0] f_first_set(input logic [NUM_NODES-1:0] v);
    f_first_set = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--)
      if (v[i]) f_first_set = NODE_W'(i);
  endfunction

  assign w_node_ok     = ({1'b0, i_req_node} < (NODE_W + 1)'(NUM_NODES));
  assign w_accept      = i_req_valid && (r_fsm == S_IDLE);
  assign w_cur_state   = r_state_tbl[r_index];
  assign w_cur_sharers = r_sharer_tbl[r_index];
  assign w_req_oh      = c_ONE << r_node;
  assign w_others      = w_cur_sharers & ~w_req_oh;
  // A MODIFIED entry holds exactly one sharer bit, so the lowest set bit is the owner.
  assign w_owner       = f_first_set(w_cur_sharers);

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_pending_nxt = r_pending;
    w_new_state   = r_new_state;
    w_new_sharers = r_new_sharers;
    w_reply_state = r_reply_state;
    w_inv_valid   = 1'b0;
    w_inv_mask    = '0;
    w_fetch_valid = 1'b0;
    w_fetch_node  = '0;
    w_fetch_inval = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (w_accept && w_node_ok) w_fsm_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_fsm_nxt = S_REPLY;
        case (r_type)
          c_REQ_RD: begin
            w_reply_state = c_SHARED;
            w_new_state   = c_SHARED;
            w_new_sharers = w_req_oh;
            if (w_cur_state == c_SHARED) begin
              w_new_sharers = w_cur_sharers | w_req_oh;
            end else if (w_cur_state == c_MODIFIED && w_owner != r_node) begin
              w_new_sharers = w_cur_sharers | w_req_oh;
              w_fetch_valid = 1'b1;
              w_fetch_node  = w_owner;
              w_pending_nxt = c_ONE << w_owner;
              w_fsm_nxt     = S_FETCH_WAIT;
            end
          end
          c_REQ_WB: begin
            w_reply_state = w_cur_state;
            w_new_state   = w_cur_state;
            w_new_sharers = w_cur_sharers;
            if (w_cur_state == c_MODIFIED && w_owner == r_node) begin
              w_reply_state = c_UNCACHED;
              w_new_state   = c_UNCACHED;
              w_new_sharers = '0;
            end
          end
          default: begin
            // Write miss and upgrade share one path: an upgrade may have lost a race.
            w_reply_state = c_MODIFIED;
            w_new_state   = c_MODIFIED;
            w_new_sharers = w_req_oh;
            if (w_cur_state == c_SHARED && w_others != '0) begin
              w_inv_valid   = 1'b1;
              w_inv_mask    = w_others;
              w_pending_nxt = w_others;
              w_fsm_nxt     = S_INVAL_WAIT;
            end else if (w_cur_state == c_MODIFIED && w_owner != r_node) begin
              w_fetch_valid = 1'b1;
              w_fetch_node  = w_owner;
              w_fetch_inval = 1'b1;
              w_pending_nxt = c_ONE << w_owner;
              w_fsm_nxt     = S_FETCH_WAIT;
            end
          end
        endcase
      end
      S_INVAL_WAIT, S_FETCH_WAIT: begin
        if (i_ack_valid) w_pending_nxt = r_pending & ~(c_ONE << i_ack_node);
        if (w_pending_nxt == '0) w_fsm_nxt = S_REPLY;
      end
      S_REPLY: w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm         <= S_IDLE;
      r_type        <= '0;
      r_node        <= '0;
      r_index       <= '0;
      r_pending     <= '0;
      r_new_state   <= '0;
      r_new_sharers <= '0;
      r_reply_state <= '0;
    end else begin
      r_fsm         <= w_fsm_nxt;
      r_pending     <= w_pending_nxt;
      r_new_state   <= w_new_state;
      r_new_sharers <= w_new_sharers;
      r_reply_state <= w_reply_state;
      if (w_accept && w_node_ok) begin
        r_type  <= i_req_type;
        r_node  <= i_req_node;
        r_index <= i_req_index;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_state_tbl[i]  <= c_UNCACHED;
        r_sharer_tbl[i] <= '0;
      end
    end else if (r_fsm == S_REPLY) begin
      r_state_tbl[r_index]  <= r_new_state;
      r_sharer_tbl[r_index] <= r_new_sharers;
    end
  end

  assign o_req_ready   = (r_fsm == S_IDLE);
  assign o_busy        = (r_fsm != S_IDLE);
  assign o_inv_valid   = w_inv_valid;
  assign o_inv_mask    = w_inv_mask;
  assign o_fetch_valid = w_fetch_valid;
  assign o_fetch_node  = w_fetch_node;
  assign o_fetch_inval = w_fetch_inval;
  assign o_reply_valid = (r_fsm == S_REPLY);
  assign o_reply_node  = r_node;
  assign o_reply_state = r_reply_state;

`ifdef DIR_STATS_EN
  logic [15:0] r_stat_inval, r_stat_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_inval <= '0;
      r_stat_fetch <= '0;
    end else begin
      if (w_inv_valid && r_stat_inval != 16'hFFFF) r_stat_inval <= r_stat_inval + 16'd1;
      if (w_fetch_valid && r_stat_fetch != 16'hFFFF) r_stat_fetch <= r_stat_fetch + 16'd1;
    end
  end

  assign o_stat_inval = r_stat_inval;
  assign o_stat_fetch = r_stat_fetch;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_directory_controller.sv
`default_nettype none
// ============================================================================
// tb_directory_controller : scoreboard bench for directory_controller
// Revision: 1.0
// ============================================================================
module tb_directory_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_type = '0;
  logic [1:0] req_node = '0;
  logic [3:0] req_index = '0;
  logic       inv_valid;
  logic [3:0] inv_mask;
  logic       fetch_valid;
  logic [1:0] fetch_node;
  logic       fetch_inval;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_node = '0;
  logic       reply_valid;
  logic [1:0] reply_node;
  logic [1:0] reply_state;
  logic       busy;
`ifdef DIR_STATS_EN
  logic [15:0] stat_inval, stat_fetch;
`endif

  directory_controller #(.NUM_NODES(4), .NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_type(req_type),
    .i_req_node(req_node), .i_req_index(req_index),
    .o_inv_valid(inv_valid), .o_inv_mask(inv_mask),
    .o_fetch_valid(fetch_valid), .o_fetch_node(fetch_node), .o_fetch_inval(fetch_inval),
    .i_ack_valid(ack_valid), .i_ack_node(ack_node),
    .o_reply_valid(reply_valid), .o_reply_node(reply_node), .o_reply_state(reply_state),
    .o_busy(busy)
`ifdef DIR_STATS_EN
    , .o_stat_inval(stat_inval), .o_stat_fetch(stat_fetch)
`endif
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         reply_cnt = 0;
  int         last_reply_cyc = -1;
  logic [3:0] exp_q [$];
  logic [1:0] m_st [16];
  logic [3:0] m_sh [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every reply pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && reply_valid) begin
      logic [3:0] e;
      if (exp_q.size() == 0) begin
        check("reply_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("reply_node", 32'(reply_node), 32'(e[3:2]));
        check("reply_state", 32'(reply_state), 32'(e[1:0]));
      end
      reply_cnt++;
      last_reply_cyc = cyc;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i] = 2'b01;
      m_sh[i] = 4'b0000;
    end
  endtask

  task automatic do_req(input logic [1:0] typ, input int node, input int idx,
                        input logic [7:0] acks, input int nacks, input int spur,
                        input bit abort);
    logic [1:0] cs, rs, ns;
    logic [3:0] sh, ro, nsh, mask;
    logic [1:0] nd;
    int own, acc, last, base;
    bit e_inv, e_fetch, e_finv;
    nd = 2'(node);
    cs = m_st[idx]; sh = m_sh[idx]; ro = 4'b0001 << nd;
    own = 0;
    for (int i = 3; i >= 0; i--) if (sh[i]) own = i;
    e_inv = 0; e_fetch = 0; e_finv = 0; mask = '0;
    case (typ)
      2'b00: begin
        rs = 2'b10; ns = 2'b10; nsh = ro;
        if (cs == 2'b10) nsh = sh | ro;
        else if (cs == 2'b11 && own != node) begin nsh = sh | ro; e_fetch = 1; end
      end
      2'b11: begin
        rs = cs; ns = cs; nsh = sh;
        if (cs == 2'b11 && own == node) begin rs = 2'b01; ns = 2'b01; nsh = '0; end
      end
      default: begin
        rs = 2'b11; ns = 2'b11; nsh = ro;
        if (cs == 2'b10 && (sh & ~ro) != 4'b0) begin e_inv = 1; mask = sh & ~ro; end
        else if (cs == 2'b11 && own != node) begin e_fetch = 1; e_finv = 1; end
      end
    endcase
    m_st[idx] = ns; m_sh[idx] = nsh;
    exp_q.push_back({nd, rs});

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = typ; req_node = nd; req_index = 4'(idx);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    base = reply_cnt;
    @(negedge clk);
    check("busy_lookup", 32'(busy), 32'd1);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("inv_valid", 32'(inv_valid), 32'(e_inv));
    if (e_inv) check("inv_mask", 32'(inv_mask), 32'(mask));
    check("fetch_valid", 32'(fetch_valid), 32'(e_fetch));
    if (e_fetch) begin
      check("fetch_node", 32'(fetch_node), 32'(own));
      check("fetch_inval", 32'(fetch_inval), 32'(e_finv));
    end
    last = acc;

    if (abort) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_reply", 32'(reply_valid), 32'd0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      check("abort_noreply", 32'(reply_cnt - base), 32'd0);
      return;
    end

    if (spur >= 0) begin
      @(negedge clk);
      ack_valid = 1'b1; ack_node = 2'(spur);
      @(posedge clk); #1;
      ack_valid = 1'b0;
    end
    for (int i = 0; i < nacks; i++) begin
      @(negedge clk);
      ack_valid = 1'b1; ack_node = acks[2*i +: 2];
      last = cyc;
      @(posedge clk); #1;
      ack_valid = 1'b0;
    end
    for (int i = 0; i < 20 && reply_cnt == base; i++) @(posedge clk);
    check("reply_count", 32'(reply_cnt - base), 32'd1);
    check("reply_cycle", 32'(last_reply_cyc), 32'(last + 1));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reply", 32'(reply_valid), 32'd0);
    check("rst_inv", 32'(inv_valid), 32'd0);
    check("rst_fetch", 32'(fetch_valid), 32'd0);
    check("rst_rstate", 32'(reply_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_req(2'b00, 0, 3, 8'h00, 0, -1, 0);   // UNCACHED read, no remote action
    do_req(2'b00, 1, 3, 8'h00, 0, -1, 0);
    do_req(2'b00, 2, 3, 8'h00, 0, -1, 0);
    do_req(2'b01, 3, 3, 8'h18, 3, -1, 0);   // acks 0,2,1
    do_req(2'b00, 0, 3, 8'h03, 1, -1, 0);   // fetch from owner 3
    do_req(2'b01, 0, 3, 8'h03, 1, -1, 0);   // invalidate remaining sharer 3
    do_req(2'b01, 1, 5, 8'h00, 0, -1, 0);
    do_req(2'b11, 2, 5, 8'h00, 0, -1, 0);   // stale write-back
    do_req(2'b11, 1, 5, 8'h00, 0, -1, 0);
    do_req(2'b00, 0, 7, 8'h00, 0, -1, 0);
    do_req(2'b00, 1, 7, 8'h00, 0, -1, 0);
    do_req(2'b01, 2, 7, 8'h04, 2, 2, 0);    // spurious ack from n2 first
    do_req(2'b10, 1, 7, 8'h02, 1, -1, 0);   // upgrade against owner n2
    do_req(2'b01, 1, 7, 8'h00, 0, -1, 0);
    do_req(2'b00, 1, 7, 8'h00, 0, -1, 0);
    do_req(2'b11, 3, 9, 8'h00, 0, -1, 0);
    do_req(2'b00, 3, 15, 8'h00, 0, -1, 0);
    do_req(2'b01, 0, 15, 8'h03, 1, -1, 0);
    do_req(2'b00, 2, 3, 8'h00, 0, -1, 1);   // reset during FETCH_WAIT
    do_req(2'b00, 1, 3, 8'h00, 0, -1, 0);
    do_req(2'b01, 2, 7, 8'h00, 0, -1, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
